read_scoreboard: RTL and testbench

- Hazard controller for the register-read stage.
- Tracks per-architectural-register pending writes between read-stage issue and writeback.
- Drives the read stage's stall and can-read controls so operands are only read once their producers have retired.
- Sits between decode/read and writeback; one instruction is considered per cycle.

---
 rtl/read_scoreboard.sv | 117 +++++++++++
 tb/tb_read_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/read_scoreboard.sv
// Register-read hazard scoreboard: per-register pending-write counters gate issue
// until every producer of a source operand has retired through writeback.
module read_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issueIn,
  input  logic [0:3]          sourceReg1In,
  input  logic                sourceReg1ValidIn,
  input  logic [0:3]          sourceReg2In,
  input  logic                sourceReg2ValidIn,
  input  logic [0:3]          destRegIn,
  input  logic                destRegValidIn,
  input  logic [0:3]          destRegisterSpecialIn,
  input  logic                destRegisterSpecialValidIn,
  input  logic [0:3]          writebackRegIn,
  input  logic                writebackValidIn,
  input  logic [0:3]          writebackSpecialRegIn,
  input  logic                writebackSpecialValidIn,
  input  logic                flushIn,
  output logic                stallOut,
  output logic                canReadOut,
  output logic [NUM_REGS-1:0] busyMaskOut,
  output logic                errorOut
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic                error_q;
  logic                error_d;
  logic [NUM_REGS-1:0] busy_s;
  logic [NUM_REGS-1:0] sat_s;
  logic [NUM_REGS-1:0] inc_s;
  logic [NUM_REGS-1:0] dec_s;
  logic                src_haz_s;
  logic                sat_haz_s;

  // Busy and saturation flags come from registered counters only (no writeback bypass).
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_s[r] = (cnt_q[r] != CNT_ZERO);
      sat_s[r]  = (cnt_q[r] == CNT_MAX);
    end
  end

  // Hazard detection and same-cycle grant.
  always_comb begin
    src_haz_s  = (sourceReg1ValidIn && busy_s[sourceReg1In]) ||
                 (sourceReg2ValidIn && busy_s[sourceReg2In]);
    sat_haz_s  = (destRegValidIn && sat_s[destRegIn]) ||
                 (destRegisterSpecialValidIn && sat_s[destRegisterSpecialIn]);
    stallOut   = issueIn && !flushIn && (src_haz_s || sat_haz_s);
    canReadOut = issueIn && !flushIn && !stallOut;
  end

  // One-hot increment/decrement masks; equal dual targets collapse to a single step.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_s[r] = canReadOut &&
                 ((destRegValidIn && (destRegIn == 4'(r))) ||
                  (destRegisterSpecialValidIn && (destRegisterSpecialIn == 4'(r))));
      dec_s[r] = (writebackValidIn && (writebackRegIn == 4'(r))) ||
                 (writebackSpecialValidIn && (writebackSpecialRegIn == 4'(r)));
    end
  end

  // Counter next state; flush wins over both issue and writeback.
  always_comb begin
    error_d = error_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    if (flushIn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_d[r] = CNT_ZERO;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        case ({inc_s[r], dec_s[r]})
          2'b10: cnt_d[r] = cnt_q[r] + {{(CNT_W-1){1'b0}}, 1'b1};
          2'b01: begin
            if (cnt_q[r] == CNT_ZERO) begin
              error_d = 1'b1;
            end else begin
              cnt_d[r] = cnt_q[r] - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          default: cnt_d[r] = cnt_q[r];
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= CNT_ZERO;
      end
      error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      error_q <= error_d;
    end
  end

  assign busyMaskOut = busy_s;
  assign errorOut    = error_q;

endmodule

// File: tb/tb_read_scoreboard.sv
// Scoreboard bench for read_scoreboard: the driver queues hand-computed expectations
// per cycle, and a negedge monitor pops and compares them against the DUT outputs.
module tb_read_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issueIn;
  logic [0:3]  sourceReg1In;
  logic        sourceReg1ValidIn;
  logic [0:3]  sourceReg2In;
  logic        sourceReg2ValidIn;
  logic [0:3]  destRegIn;
  logic        destRegValidIn;
  logic [0:3]  destRegisterSpecialIn;
  logic        destRegisterSpecialValidIn;
  logic [0:3]  writebackRegIn;
  logic        writebackValidIn;
  logic [0:3]  writebackSpecialRegIn;
  logic        writebackSpecialValidIn;
  logic        flushIn;
  logic        stallOut;
  logic        canReadOut;
  logic [15:0] busyMaskOut;
  logic        errorOut;

  typedef struct {
    string       name;
    logic        stall;
    logic        can;
    logic [15:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  read_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .issueIn                    (issueIn),
    .sourceReg1In               (sourceReg1In),
    .sourceReg1ValidIn          (sourceReg1ValidIn),
    .sourceReg2In               (sourceReg2In),
    .sourceReg2ValidIn          (sourceReg2ValidIn),
    .destRegIn                  (destRegIn),
    .destRegValidIn             (destRegValidIn),
    .destRegisterSpecialIn      (destRegisterSpecialIn),
    .destRegisterSpecialValidIn (destRegisterSpecialValidIn),
    .writebackRegIn             (writebackRegIn),
    .writebackValidIn           (writebackValidIn),
    .writebackSpecialRegIn      (writebackSpecialRegIn),
    .writebackSpecialValidIn    (writebackSpecialValidIn),
    .flushIn                    (flushIn),
    .stallOut                   (stallOut),
    .canReadOut                 (canReadOut),
    .busyMaskOut                (busyMaskOut),
    .errorOut                   (errorOut)
  );

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (stallOut !== e.stall) begin
        errors++;
        $display("FAIL %s stall: got %b expected %b", e.name, stallOut, e.stall);
      end
      checks++;
      if (canReadOut !== e.can) begin
        errors++;
        $display("FAIL %s canRead: got %b expected %b", e.name, canReadOut, e.can);
      end
      checks++;
      if (busyMaskOut !== e.busy) begin
        errors++;
        $display("FAIL %s busyMask: got %h expected %h", e.name, busyMaskOut, e.busy);
      end
      checks++;
      if (errorOut !== e.err) begin
        errors++;
        $display("FAIL %s error: got %b expected %b", e.name, errorOut, e.err);
      end
    end
  end

  task automatic idle();
    issueIn = 1'b0;
    sourceReg1In = 4'd0;  sourceReg1ValidIn = 1'b0;
    sourceReg2In = 4'd0;  sourceReg2ValidIn = 1'b0;
    destRegIn = 4'd0;     destRegValidIn = 1'b0;
    destRegisterSpecialIn = 4'd0; destRegisterSpecialValidIn = 1'b0;
    writebackRegIn = 4'd0; writebackValidIn = 1'b0;
    writebackSpecialRegIn = 4'd0; writebackSpecialValidIn = 1'b0;
    flushIn = 1'b0;
  endtask

  // Inputs are already set for this cycle; queue the expectation, advance, clear inputs.
  task automatic cyc(input string nm, input logic st, input logic cr,
                     input logic [15:0] bm, input logic er);
    exp_t e;
    e.name = nm; e.stall = st; e.can = cr; e.busy = bm; e.err = er;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue_dest(input logic [3:0] d);
    issueIn = 1'b1; destRegIn = d; destRegValidIn = 1'b1;
  endtask

  task automatic issue_src1(input logic [3:0] s);
    issueIn = 1'b1; sourceReg1In = s; sourceReg1ValidIn = 1'b1;
  endtask

  task automatic wb(input logic [3:0] w);
    writebackRegIn = w; writebackValidIn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    cyc("reset", 1'b0, 1'b0, 16'h0000, 1'b0);
    reset = 1'b0;

    // Issue dest 3, then a reader of r3 stalls until the cycle after writeback.
    issue_dest(4'd3);                cyc("t1_issue",  1'b0, 1'b1, 16'h0000, 1'b0);
    issue_src1(4'd3);                cyc("t2_stall",  1'b1, 1'b0, 16'h0008, 1'b0);
    issue_src1(4'd3); wb(4'd3);      cyc("t2_wbN",    1'b1, 1'b0, 16'h0008, 1'b0);
    issue_src1(4'd3);                cyc("t2_N1",     1'b0, 1'b1, 16'h0000, 1'b0);

    // Saturate r5, then release one slot via writeback.
    issue_dest(4'd5);                cyc("t3_i1",     1'b0, 1'b1, 16'h0000, 1'b0);
    issue_dest(4'd5);                cyc("t3_i2",     1'b0, 1'b1, 16'h0020, 1'b0);
    issue_dest(4'd5);                cyc("t3_i3",     1'b0, 1'b1, 16'h0020, 1'b0);
    issue_dest(4'd5); wb(4'd5);      cyc("t3_sat",    1'b1, 1'b0, 16'h0020, 1'b0);
    issue_dest(4'd5);                cyc("t3_regrant",1'b0, 1'b1, 16'h0020, 1'b0);
    issue_dest(4'd5);                cyc("t3_resat",  1'b1, 1'b0, 16'h0020, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wb(4'd5);                      cyc("t3_drain",  1'b0, 1'b0, 16'h0020, 1'b0);
    end

    // Dual destination and dual writeback.
    issue_dest(4'd0);
    destRegisterSpecialIn = 4'd2; destRegisterSpecialValidIn = 1'b1;
                                     cyc("t4_imul",   1'b0, 1'b1, 16'h0000, 1'b0);
    wb(4'd0);
    writebackSpecialRegIn = 4'd2; writebackSpecialValidIn = 1'b1;
                                     cyc("t4_dualwb", 1'b0, 1'b0, 16'h0005, 1'b0);
    issue_dest(4'd7);
    destRegisterSpecialIn = 4'd7; destRegisterSpecialValidIn = 1'b1;
                                     cyc("t4_same",   1'b0, 1'b1, 16'h0000, 1'b0);
    wb(4'd7);                        cyc("t4_wb7",    1'b0, 1'b0, 16'h0080, 1'b0);

    // Writeback with nothing pending: sticky error.
    wb(4'd9);                        cyc("t5_wb9",    1'b0, 1'b0, 16'h0000, 1'b0);
    cyc("t5_err",    1'b0, 1'b0, 16'h0000, 1'b1);
    cyc("t5_sticky", 1'b0, 1'b0, 16'h0000, 1'b1);

    // Build cnt[1]=2, cnt[4]=1; src2 hazard; then flush with issue and writeback.
    issue_dest(4'd1);                cyc("t6_i1",     1'b0, 1'b1, 16'h0000, 1'b1);
    issue_dest(4'd1);
    destRegisterSpecialIn = 4'd4; destRegisterSpecialValidIn = 1'b1;
                                     cyc("t6_i2",     1'b0, 1'b1, 16'h0002, 1'b1);
    issueIn = 1'b1; sourceReg1In = 4'd1; sourceReg1ValidIn = 1'b0;
    sourceReg2In = 4'd4; sourceReg2ValidIn = 1'b1;
                                     cyc("t6_src2",   1'b1, 1'b0, 16'h0012, 1'b1);
    issue_dest(4'd6); wb(4'd1); flushIn = 1'b1;
                                     cyc("t6_flush",  1'b0, 1'b0, 16'h0012, 1'b1);
    cyc("t6_post",   1'b0, 1'b0, 16'h0000, 1'b1);

    // Async reset mid-stream clears state and the sticky error.
    issue_dest(4'd2);                cyc("t7_i2",     1'b0, 1'b1, 16'h0000, 1'b1);
    reset = 1'b1;                    cyc("t7_reset",  1'b0, 1'b0, 16'h0000, 1'b0);
    reset = 1'b0;
    issue_src1(4'd2);                cyc("t7_after",  1'b0, 1'b1, 16'h0000, 1'b0);

    // Writeback to an idle register during flush must not raise error.
    wb(4'd9); flushIn = 1'b1;        cyc("t8_flushwb",1'b0, 1'b0, 16'h0000, 1'b0);
    cyc("t8_noerr",  1'b0, 1'b0, 16'h0000, 1'b0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
